// File: rtl/countdown_sequencer_if.sv
// Front-panel countdown handshake: button pulses and load value in, display state out.
// The master drives the debounced button pulses; the sequencer is the slave.
interface countdown_sequencer_if #(
  parameter int unsigned SEC_W = 8
);

  logic             start;
  logic             pause;
  logic             clear;
  logic [SEC_W-1:0] load_val;
  logic [SEC_W-1:0] remaining;
  logic             running;
  logic             paused;
  logic             done;
  logic             blink;
  logic             sec_tick;

  modport master (
    output start,
    output pause,
    output clear,
    output load_val,
    input  remaining,
    input  running,
    input  paused,
    input  done,
    input  blink,
    input  sec_tick
  );

  modport slave (
    input  start,
    input  pause,
    input  clear,
    input  load_val,
    output remaining,
    output running,
    output paused,
    output done,
    output blink,
    output sec_tick
  );

endinterface

// File: rtl/countdown_sequencer.sv
// Seconds countdown sequencer: one shared prescaler drives the RUN decrements and the
// alarm-phase seconds, with a blink divider active only while the alarm is showing.
module countdown_sequencer #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned BLINK_DIV = 50000000,
  parameter int unsigned ALARM_SEC = 5,
  parameter int unsigned SEC_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  countdown_sequencer_if.slave        bus
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned AlmW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [PreW-1:0]  PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [BlkW-1:0]  BlkMax  = BlkW'(BLINK_DIV - 1);
  localparam logic [AlmW-1:0]  AlmLast = AlmW'(ALARM_SEC - 1);
  localparam logic [SEC_W-1:0] SecOne  = SEC_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StExpire
  } state_e;

  state_e           state_q;
  logic [PreW-1:0]  pre_q;
  logic [BlkW-1:0]  blk_q;
  logic [AlmW-1:0]  alm_q;
  logic [SEC_W-1:0] remaining_q;
  logic             running_q;
  logic             paused_q;
  logic             done_q;
  logic             blink_q;
  logic             sec_tick_q;

  logic pre_wrap;
  logic blk_wrap;
  logic alm_last;
  logic start_load;
  logic pause_req;

  assign pre_wrap   = (pre_q == PreMax);
  assign blk_wrap   = (blk_q == BlkMax);
  assign alm_last   = (alm_q == AlmLast);
  assign start_load = bus.start && (bus.load_val != '0);
  // start outranks pause even in RUN, where start itself has no effect
  assign pause_req  = bus.pause && !bus.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pre_q       <= '0;
      blk_q       <= '0;
      alm_q       <= '0;
      remaining_q <= '0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
      blink_q     <= 1'b0;
      sec_tick_q  <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      if (bus.clear) begin
        state_q     <= StIdle;
        pre_q       <= '0;
        blk_q       <= '0;
        alm_q       <= '0;
        remaining_q <= '0;
        running_q   <= 1'b0;
        paused_q    <= 1'b0;
        done_q      <= 1'b0;
        blink_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_load) begin
              state_q     <= StRun;
              pre_q       <= '0;
              blk_q       <= '0;
              alm_q       <= '0;
              remaining_q <= bus.load_val;
              running_q   <= 1'b1;
              paused_q    <= 1'b0;
              done_q      <= 1'b0;
              blink_q     <= 1'b0;
            end
          end

          StRun: begin
            pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
            if (pre_wrap && (remaining_q <= SecOne)) begin
              // Final second elapsed: expiry wins over a coincident pause
              sec_tick_q  <= 1'b1;
              remaining_q <= '0;
              state_q     <= StExpire;
              blk_q       <= '0;
              alm_q       <= '0;
              running_q   <= 1'b0;
              paused_q    <= 1'b0;
              done_q      <= 1'b1;
              blink_q     <= 1'b1;
            end else begin
              if (pre_wrap) begin
                sec_tick_q  <= 1'b1;
                remaining_q <= remaining_q - 1'b1;
              end
              if (pause_req) begin
                state_q   <= StPause;
                running_q <= 1'b0;
                paused_q  <= 1'b1;
              end
            end
          end

          StPause: begin
            // Prescaler is held so the partial second survives the pause
            if (bus.start) begin
              state_q   <= StRun;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end
          end

          StExpire: begin
            if (start_load) begin
              state_q     <= StRun;
              pre_q       <= '0;
              blk_q       <= '0;
              alm_q       <= '0;
              remaining_q <= bus.load_val;
              running_q   <= 1'b1;
              paused_q    <= 1'b0;
              done_q      <= 1'b0;
              blink_q     <= 1'b0;
            end else begin
              pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
              if (blk_wrap) begin
                blk_q   <= '0;
                blink_q <= ~blink_q;
              end else begin
                blk_q <= blk_q + 1'b1;
              end
              if (pre_wrap) begin
                if (alm_last) begin
                  state_q <= StIdle;
                  alm_q   <= '0;
                  blk_q   <= '0;
                  done_q  <= 1'b0;
                  blink_q <= 1'b0;
                end else begin
                  alm_q <= alm_q + 1'b1;
                end
              end
            end
          end

          default: begin
            state_q     <= StIdle;
            pre_q       <= '0;
            blk_q       <= '0;
            alm_q       <= '0;
            remaining_q <= '0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
            blink_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.remaining = remaining_q;
  assign bus.running   = running_q;
  assign bus.paused    = paused_q;
  assign bus.done      = done_q;
  assign bus.blink     = blink_q;
  assign bus.sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with small dividers (10/5/2) so every phase is short.
module tb_countdown_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  countdown_sequencer_if #(.SEC_W(8)) bus ();

  countdown_sequencer #(
    .TICK_DIV (10),
    .BLINK_DIV(5),
    .ALARM_SEC(2),
    .SEC_W    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges and land 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] val);
    bus.load_val = val;
    bus.start    = 1'b1;
    cyc(1);
    bus.start    = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.clear    = 1'b0;
    bus.load_val = 8'd0;
    cyc(2);
    n_cmp++;
    if ({bus.remaining, bus.running, bus.paused, bus.done, bus.blink, bus.sec_tick} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs got rem=%0d run=%b pau=%b done=%b blink=%b tick=%b want all 0",
               bus.remaining, bus.running, bus.paused, bus.done, bus.blink, bus.sec_tick);
    end
    rst = 1'b1;
    cyc(2);
    n_cmp++;
    if (bus.running !== 1'b0 || bus.remaining !== 8'd0) begin
      n_err++;
      $display("FAIL reset_release_idle got run=%b rem=%0d want run=0 rem=0",
               bus.running, bus.remaining);
    end
  endtask

  // Load 3: decrements at 10, 20, 30 edges after the start edge; ends in EXPIRE
  task automatic test_basic_countdown();
    int ticks;
    logic [7:0] exp_rem;
    logic       exp_tick;
    ticks = 0;
    pulse_start(8'd3);
    n_cmp++;
    if (bus.running !== 1'b1 || bus.remaining !== 8'd3 || bus.sec_tick !== 1'b0) begin
      n_err++;
      $display("FAIL basic_load got run=%b rem=%0d tick=%b want run=1 rem=3 tick=0",
               bus.running, bus.remaining, bus.sec_tick);
    end
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      exp_rem  = 8'(3 - i / 10);
      exp_tick = (i % 10 == 0);
      if (bus.sec_tick === 1'b1) ticks++;
      n_cmp++;
      if (bus.remaining !== exp_rem || bus.sec_tick !== exp_tick) begin
        n_err++;
        $display("FAIL basic_cycle%0d got rem=%0d tick=%b want rem=%0d tick=%b",
                 i, bus.remaining, bus.sec_tick, exp_rem, exp_tick);
      end
    end
    n_cmp++;
    if (ticks != 3) begin
      n_err++;
      $display("FAIL basic_tick_count got %0d want 3", ticks);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.blink !== 1'b1) begin
      n_err++;
      $display("FAIL basic_expire got done=%b run=%b blink=%b want done=1 run=0 blink=1",
               bus.done, bus.running, bus.blink);
    end
  endtask

  // Entered right at the expiry edge: 5 on / 5 off / 5 on / 5 off, then idle
  task automatic test_alarm();
    logic exp_blink;
    logic exp_done;
    for (int j = 1; j <= 20; j++) begin
      cyc(1);
      exp_blink = (j < 20) && ((j / 5) % 2 == 0);
      exp_done  = (j < 20);
      n_cmp++;
      if (bus.blink !== exp_blink || bus.done !== exp_done || bus.sec_tick !== 1'b0) begin
        n_err++;
        $display("FAIL alarm_cycle%0d got blink=%b done=%b tick=%b want blink=%b done=%b tick=0",
                 j, bus.blink, bus.done, bus.sec_tick, exp_blink, exp_done);
      end
    end
    cyc(12);
    n_cmp++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.blink !== 1'b0 ||
        bus.remaining !== 8'd0) begin
      n_err++;
      $display("FAIL alarm_idle got run=%b done=%b blink=%b rem=%0d want 0/0/0/0",
               bus.running, bus.done, bus.blink, bus.remaining);
    end
  endtask

  // Pause after 4 counted cycles; resume must decrement 6 edges later
  task automatic test_pause_resume();
    logic [7:0] exp_rem;
    pulse_start(8'd5);
    cyc(3);
    bus.pause = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
    n_cmp++;
    if (bus.paused !== 1'b1 || bus.running !== 1'b0 || bus.remaining !== 8'd5) begin
      n_err++;
      $display("FAIL pause_enter got pau=%b run=%b rem=%0d want pau=1 run=0 rem=5",
               bus.paused, bus.running, bus.remaining);
    end
    for (int i = 1; i <= 20; i++) begin
      if (i == 10) bus.pause = 1'b1;
      cyc(1);
      bus.pause = 1'b0;
      n_cmp++;
      if (bus.remaining !== 8'd5 || bus.sec_tick !== 1'b0 || bus.paused !== 1'b1) begin
        n_err++;
        $display("FAIL pause_hold%0d got rem=%0d tick=%b pau=%b want rem=5 tick=0 pau=1",
                 i, bus.remaining, bus.sec_tick, bus.paused);
      end
    end
    pulse_start(8'd9);
    n_cmp++;
    if (bus.running !== 1'b1 || bus.paused !== 1'b0 || bus.remaining !== 8'd5) begin
      n_err++;
      $display("FAIL resume got run=%b pau=%b rem=%0d want run=1 pau=0 rem=5",
               bus.running, bus.paused, bus.remaining);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      exp_rem = (i == 6) ? 8'd4 : 8'd5;
      n_cmp++;
      if (bus.remaining !== exp_rem || bus.sec_tick !== (i == 6)) begin
        n_err++;
        $display("FAIL resume_cycle%0d got rem=%0d tick=%b want rem=%0d tick=%b",
                 i, bus.remaining, bus.sec_tick, exp_rem, (i == 6));
      end
    end
    pulse_clear();
    n_cmp++;
    if (bus.running !== 1'b0 || bus.remaining !== 8'd0) begin
      n_err++;
      $display("FAIL pause_clear got run=%b rem=%0d want run=0 rem=0",
               bus.running, bus.remaining);
    end
  endtask

  task automatic test_priorities();
    pulse_start(8'd7);
    cyc(3);
    bus.clear    = 1'b1;
    bus.start    = 1'b1;
    bus.load_val = 8'd9;
    cyc(1);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.running !== 1'b0 || bus.remaining !== 8'd0) begin
      n_err++;
      $display("FAIL clear_over_start got run=%b rem=%0d want run=0 rem=0",
               bus.running, bus.remaining);
    end
    pulse_start(8'd0);
    cyc(1);
    n_cmp++;
    if (bus.running !== 1'b0 || bus.remaining !== 8'd0) begin
      n_err++;
      $display("FAIL idle_start_zero got run=%b rem=%0d want run=0 rem=0",
               bus.running, bus.remaining);
    end
    bus.pause = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
    n_cmp++;
    if (bus.paused !== 1'b0 || bus.running !== 1'b0) begin
      n_err++;
      $display("FAIL idle_pause got pau=%b run=%b want pau=0 run=0", bus.paused, bus.running);
    end
    pulse_start(8'd255);
    n_cmp++;
    if (bus.remaining !== 8'd255 || bus.running !== 1'b1) begin
      n_err++;
      $display("FAIL load_max got rem=%0d run=%b want rem=255 run=1",
               bus.remaining, bus.running);
    end
    pulse_clear();
  endtask

  task automatic test_reload_expire();
    pulse_start(8'd1);
    cyc(10);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.remaining !== 8'd0) begin
      n_err++;
      $display("FAIL reload_expired got done=%b rem=%0d want done=1 rem=0",
               bus.done, bus.remaining);
    end
    cyc(2);
    pulse_start(8'd0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0) begin
      n_err++;
      $display("FAIL expire_start_zero got done=%b run=%b want done=1 run=0",
               bus.done, bus.running);
    end
    pulse_start(8'd2);
    n_cmp++;
    if (bus.running !== 1'b1 || bus.done !== 1'b0 || bus.blink !== 1'b0 ||
        bus.remaining !== 8'd2) begin
      n_err++;
      $display("FAIL reload got run=%b done=%b blink=%b rem=%0d want 1/0/0/2",
               bus.running, bus.done, bus.blink, bus.remaining);
    end
    cyc(9);
    n_cmp++;
    if (bus.remaining !== 8'd2) begin
      n_err++;
      $display("FAIL reload_hold got rem=%0d want 2", bus.remaining);
    end
    cyc(1);
    n_cmp++;
    if (bus.remaining !== 8'd1 || bus.sec_tick !== 1'b1) begin
      n_err++;
      $display("FAIL reload_first_tick got rem=%0d tick=%b want rem=1 tick=1",
               bus.remaining, bus.sec_tick);
    end
    pulse_clear();
  endtask

  task automatic test_async_reset();
    pulse_start(8'd4);
    cyc(5);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.remaining !== 8'd0 || bus.running !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got rem=%0d run=%b want rem=0 run=0",
               bus.remaining, bus.running);
    end
    cyc(2);
    rst = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc(1);
      n_cmp++;
      if (bus.running !== 1'b0 || bus.remaining !== 8'd0 || bus.sec_tick !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle%0d got run=%b rem=%0d tick=%b want 0/0/0",
                 i, bus.running, bus.remaining, bus.sec_tick);
      end
    end
    pulse_start(8'd1);
    n_cmp++;
    if (bus.running !== 1'b1 || bus.remaining !== 8'd1) begin
      n_err++;
      $display("FAIL post_reset_start got run=%b rem=%0d want run=1 rem=1",
               bus.running, bus.remaining);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic_countdown();
    test_alarm();
    test_pause_resume();
    test_priorities();
    test_reload_expire();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
